// File: rtl/div_repsub_pkg.sv
// Shared definitions for the repeated-subtraction divider: controller states
// and the default operand width.
package div_repsub_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LD_A,
        LD_B,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_repsub_ctrl.sv
// Controller FSM for the repeated-subtraction divider: sequences operand loads,
// one subtraction per CALC cycle, and the done handshake.
module div_repsub_ctrl
    import div_repsub_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic eqz_b,
    input  logic lt,
    output logic load_a,
    output logic load_b,
    output logic sub,
    output logic set_zero,
    output logic done
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        sub        = 1'b0;
        set_zero   = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) state_next = LD_A;
            end
            LD_A: begin
                load_a     = 1'b1;
                state_next = LD_B;
            end
            LD_B: begin
                load_b     = 1'b1;
                state_next = CALC;
            end
            CALC: begin
                // Zero divisor is tested first so it can never enter the subtract loop.
                if (eqz_b) begin
                    set_zero   = 1'b1;
                    state_next = DONE;
                end else if (!lt) begin
                    sub = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: shared operand bus, datapath with
// a single borrow-compare subtractor, controlled by div_repsub_ctrl.
module div_repsub
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_zero
);

    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] quo_reg;
    logic             zero_reg;

    logic             load_a;
    logic             load_b;
    logic             sub;
    logic             set_zero;
    logic             eqz_b;
    logic             lt;
    logic [WIDTH:0]   diff;

    // One subtractor serves as both comparator (borrow bit) and the subtract path.
    assign diff  = {1'b0, rem_reg} - {1'b0, div_reg};
    assign lt    = diff[WIDTH];
    assign eqz_b = (div_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg  <= '0;
            div_reg  <= '0;
            quo_reg  <= '0;
            zero_reg <= 1'b0;
        end else begin
            if (load_a) begin
                rem_reg <= data_in;
            end
            if (load_b) begin
                div_reg  <= data_in;
                quo_reg  <= '0;
                zero_reg <= 1'b0;
            end
            if (set_zero) begin
                quo_reg  <= '1;
                zero_reg <= 1'b1;
            end
            if (sub) begin
                rem_reg <= diff[WIDTH-1:0];
                quo_reg <= quo_reg + 1'b1;
            end
        end
    end

    div_repsub_ctrl u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .eqz_b    (eqz_b),
        .lt       (lt),
        .load_a   (load_a),
        .load_b   (load_b),
        .sub      (sub),
        .set_zero (set_zero),
        .done     (done)
    );

    assign quotient  = quo_reg;
    assign remainder = rem_reg;
    assign div_zero  = zero_reg;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: vector table feeding a scoreboard queue,
// plus hand-written reset-mid-op and held-start sequences.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    div_repsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one operation; latency counts edges from the sampling edge of start
    // to the edge at which done is first seen high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start);
        exp_t e;
        int   cnt;
        bit   seen;
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'hDEAD;
        @(posedge clk);
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 70000 && !seen) begin
            @(negedge clk);
            cnt++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (cnt == 1) begin
                    data_in = a;
                    if (!hold_start) start = 1'b0;
                end else if (cnt == 2) begin
                    data_in = b;
                end else begin
                    data_in = W'($urandom);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d/%0d no done after %0d cycles", a, b, cnt);
        end else if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: done with empty queue");
        end else begin
            e = sb.pop_front();
            check("latency", cnt, e.lat);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", div_zero, e.z);
            $display("op %0d/%0d: q=%0d r=%0d z=%0b lat=%0d", a, b, quotient, remainder, div_zero, cnt);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.q   = v.q;
        e.r   = v.r;
        e.z   = v.z;
        e.lat = v.z ? 4 : 4 + int'(v.q);
        sb.push_back(e);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{a: 16'd13,    b: 16'd4,     q: 16'd3,     r: 16'd1,  z: 1'b0};
        vecs[1] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,  z: 1'b0};
        vecs[2] = '{a: 16'd5,     b: 16'd5,     q: 16'd1,     r: 16'd0,  z: 1'b0};
        vecs[3] = '{a: 16'd7,     b: 16'd0,     q: 16'hFFFF,  r: 16'd7,  z: 1'b1};
        vecs[4] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2,  z: 1'b0};
        vecs[5] = '{a: 16'd1,     b: 16'd2,     q: 16'd0,     r: 16'd1,  z: 1'b0};
        vecs[6] = '{a: 16'd200,   b: 16'd13,    q: 16'd15,    r: 16'd5,  z: 1'b0};
        vecs[7] = '{a: 16'd65535, b: 16'd65535, q: 16'd1,     r: 16'd0,  z: 1'b0};
        vecs[8] = '{a: 16'd65535, b: 16'd1,     q: 16'd65535, r: 16'd0,  z: 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            push_exp(v);
            run_op(v.a, v.b, 1'b0);
            @(negedge clk);
            check("done drops", done, 0);
            check("hold quotient", quotient, v.q);
        end

        // Reset asserted mid-CALC must clear outputs without a clock edge.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; data_in = 16'd100;
        @(negedge clk); data_in = 16'd3;
        repeat (6) @(negedge clk);
        check("midcalc quotient nonzero", quotient != 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst quotient", quotient, 0);
        check("async rst remainder", remainder, 0);
        check("async rst done", done, 0);
        check("async rst div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{a: 16'd9, b: 16'd2, q: 16'd4, r: 16'd1, z: 1'b0};
        push_exp(v);
        run_op(v.a, v.b, 1'b0);

        // Held start: DONE persists, no re-trigger, exits one edge after release.
        @(negedge clk);
        v = '{a: 16'd20, b: 16'd6, q: 16'd3, r: 16'd2, z: 1'b0};
        push_exp(v);
        run_op(v.a, v.b, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("held done", done, 1);
            check("held quotient", quotient, 3);
            check("held remainder", remainder, 2);
        end
        start = 1'b0;
        @(negedge clk);
        check("release done", done, 0);
        repeat (4) @(negedge clk);
        check("idle done", done, 0);
        check("idle remainder", remainder, 2);
        check("scoreboard empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
